// File: rtl/fp_norm_pipe.sv
// rtl/fp_norm_pipe.sv - pipelined leading-zero mantissa normaliser with optional exponent floor
module fp_norm_pipe #(
    parameter int WIDTH = 24,
    parameter int EXP_W = 8,
    parameter int SA_W  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_mant,
    input  logic [EXP_W-1:0] in_exp,
    input  logic             in_lim,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_mant,
    output logic [EXP_W-1:0] out_exp,
    output logic [SA_W-1:0]  out_sa,
    output logic             out_zero,
    output logic             out_denorm,
    output logic             out_uflow
);
    localparam int CW = (EXP_W > SA_W) ? EXP_W : SA_W;

    logic             cap_zero;
    logic [EXP_W-1:0] cap_exp;
    logic [SA_W-1:0]  cap_budget;
    logic [CW-1:0]    exp_floor;
    logic [SA_W-1:0]  vld;
    logic [SA_W-1:0]  ld;
    logic             nxt_rdy;

    // A zero mantissa gets a zero budget so no stage ever shifts it.
    always_comb begin
        cap_zero  = ~|in_mant;
        cap_exp   = cap_zero ? '0 : in_exp;
        exp_floor = (in_exp == '0) ? '0 : CW'(in_exp) - CW'(1);
        if (cap_zero)
            cap_budget = '0;
        else if (!in_lim)
            cap_budget = '1;
        else if (exp_floor > CW'({SA_W{1'b1}}))
            cap_budget = '1;
        else
            cap_budget = exp_floor[SA_W-1:0];
    end

    always_comb begin
        nxt_rdy = out_ready;
        for (int k = 0; k < SA_W; k++) begin
            ld[k]   = ~vld[k] | nxt_rdy;
            nxt_rdy = ld[k];
        end
    end

    assign in_ready = ld[SA_W-1];

    for (genvar k = 0; k < SA_W; k++) begin : g_stage
        localparam int SH = 1 << k;

        logic             up_v, up_zero, up_lim;
        logic [WIDTH-1:0] up_mant;
        logic [EXP_W-1:0] up_exp;
        logic [SA_W-1:0]  up_sa, up_budget;
        logic             do_shift;
        logic             v_d, v_q, zero_d, zero_q;
        logic [WIDTH-1:0] mant_d, mant_q;
        logic [EXP_W-1:0] exp_d, exp_q;
        logic [SA_W-1:0]  sa_d, sa_q;

        if (k == SA_W-1) begin : g_src
            assign up_v      = in_valid;
            assign up_mant   = in_mant;
            assign up_exp    = cap_exp;
            assign up_sa     = '0;
            assign up_budget = cap_budget;
            assign up_zero   = cap_zero;
            assign up_lim    = in_lim;
        end else begin : g_src
            assign up_v      = g_stage[k+1].v_q;
            assign up_mant   = g_stage[k+1].mant_q;
            assign up_exp    = g_stage[k+1].exp_q;
            assign up_sa     = g_stage[k+1].sa_q;
            assign up_budget = g_stage[k+1].g_carry.budget_q;
            assign up_zero   = g_stage[k+1].zero_q;
            assign up_lim    = g_stage[k+1].g_carry.lim_q;
        end

        always_comb begin
            do_shift = (up_mant[WIDTH-1 -: SH] == '0) && (up_budget >= SA_W'(SH));
            v_d      = up_v;
            zero_d   = up_zero;
            mant_d   = up_mant;
            exp_d    = up_exp;
            sa_d     = up_sa;
            if (do_shift) begin
                mant_d = up_mant << SH;
                exp_d  = up_exp - EXP_W'(SH);
                sa_d   = up_sa | SA_W'(SH);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q    <= 1'b0;
                zero_q <= 1'b0;
                mant_q <= '0;
                exp_q  <= '0;
                sa_q   <= '0;
            end else if (ld[k]) begin
                v_q <= v_d;
                if (v_d) begin
                    zero_q <= zero_d;
                    mant_q <= mant_d;
                    exp_q  <= exp_d;
                    sa_q   <= sa_d;
                end
            end
        end

        assign vld[k] = v_q;

        if (k > 0) begin : g_carry
            logic [SA_W-1:0] budget_d, budget_q;
            logic            lim_q;

            always_comb budget_d = do_shift ? up_budget - SA_W'(SH) : up_budget;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    budget_q <= '0;
                    lim_q    <= 1'b0;
                end else if (ld[k] && v_d) begin
                    budget_q <= budget_d;
                    lim_q    <= up_lim;
                end
            end
        end else begin : g_flags
            logic [EXP_W-1:0] orig_exp;
            logic             denorm_d, denorm_q, uflow_d, uflow_q;

            // Original exponent is rebuilt exactly, since the wrapped subtraction is invertible.
            always_comb begin
                orig_exp = exp_d + EXP_W'(sa_d);
                denorm_d = ~zero_d & ~mant_d[WIDTH-1];
                uflow_d  = ~up_lim & ~zero_d & (CW'(sa_d) > CW'(orig_exp));
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    denorm_q <= 1'b0;
                    uflow_q  <= 1'b0;
                end else if (ld[k] && v_d) begin
                    denorm_q <= denorm_d;
                    uflow_q  <= uflow_d;
                end
            end
        end
    end

    assign out_valid  = g_stage[0].v_q;
    assign out_mant   = g_stage[0].mant_q;
    assign out_exp    = g_stage[0].exp_q;
    assign out_sa     = g_stage[0].sa_q;
    assign out_zero   = g_stage[0].zero_q;
    assign out_denorm = g_stage[0].g_flags.denorm_q;
    assign out_uflow  = g_stage[0].g_flags.uflow_q;
endmodule

// File: tb/tb_fp_norm_pipe.sv
// tb/tb_fp_norm_pipe.sv - self-checking bench for fp_norm_pipe against a leading-zero reference model
module tb_fp_norm_pipe;
    localparam int WIDTH = 24;
    localparam int EXP_W = 8;
    localparam int SA_W  = $clog2(WIDTH);
    localparam int RW    = WIDTH + EXP_W + SA_W + 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_mant = '0;
    logic [EXP_W-1:0] in_exp = '0;
    logic             in_lim = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_mant;
    logic [EXP_W-1:0] out_exp;
    logic [SA_W-1:0]  out_sa;
    logic             out_zero, out_denorm, out_uflow;
    logic [RW-1:0]    obs;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fp_norm_pipe #(.WIDTH(WIDTH), .EXP_W(EXP_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mant(in_mant), .in_exp(in_exp), .in_lim(in_lim),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_mant(out_mant), .out_exp(out_exp), .out_sa(out_sa),
        .out_zero(out_zero), .out_denorm(out_denorm), .out_uflow(out_uflow)
    );

    assign obs = {out_mant, out_exp, out_sa, out_zero, out_denorm, out_uflow};

    // Result = mantissa shifted by min(leading zeros, exponent headroom).
    function automatic logic [RW-1:0] ref_beat(input logic [WIDTH-1:0] m,
                                               input logic [EXP_W-1:0] e,
                                               input logic l);
        int lz, bud, sh;
        logic [WIDTH-1:0] rm;
        logic [EXP_W-1:0] re;
        logic             uf;
        if (m == '0) return {WIDTH'(0), EXP_W'(0), SA_W'(0), 3'b100};
        lz = 0;
        for (int i = WIDTH-1; i >= 0; i--) begin
            if (m[i]) break;
            lz++;
        end
        bud = l ? ((e == 0) ? 0 : int'(e) - 1) : WIDTH;
        sh  = (lz < bud) ? lz : bud;
        rm  = m << sh;
        re  = e - EXP_W'(sh);
        uf  = (!l && sh > int'(e));
        return {rm, re, SA_W'(sh), 1'b0, ~rm[WIDTH-1], uf};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_hold_valid: got %b want 0", out_valid); end
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_vec++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_vec++;
        if (obs !== '0) begin n_err++; $display("FAIL reset_outputs: got %h want 0", obs); end
    endtask

    task automatic test_directed();
        logic [WIDTH-1:0] tm [12];
        logic [EXP_W-1:0] te [12];
        logic             tl [12];
        logic [RW-1:0]    tr [12];
        int               n;
        tm = '{24'h000001, 24'h000F00, 24'h000F00, 24'h000000, 24'h000001, 24'h800000,
               24'h000001, 24'h000001, 24'h400000, 24'h000003, 24'h000000, 24'h123456};
        te = '{8'd100, 8'd5, 8'd0, 8'd50, 8'd10, 8'd10, 8'd24, 8'd23, 8'd0, 8'd255, 8'd3, 8'd1};
        tl = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tr = '{{24'h800000, 8'd77,  5'd23, 3'b000},
               {24'h00F000, 8'd1,   5'd4,  3'b010},
               {24'h000F00, 8'd0,   5'd0,  3'b010},
               {24'h000000, 8'd0,   5'd0,  3'b100},
               {24'h800000, 8'd243, 5'd23, 3'b001},
               {24'h800000, 8'd10,  5'd0,  3'b000},
               {24'h800000, 8'd1,   5'd23, 3'b000},
               {24'h400000, 8'd1,   5'd22, 3'b010},
               {24'h800000, 8'd255, 5'd1,  3'b001},
               {24'hC00000, 8'd233, 5'd22, 3'b000},
               {24'h000000, 8'd0,   5'd0,  3'b100},
               {24'h123456, 8'd1,   5'd0,  3'b010}};
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            in_mant = tm[i]; in_exp = te[i]; in_lim = tl[i];
            in_valid = 1'b1; out_ready = 1'b1;
            #1;
            n_vec++;
            if (in_ready !== 1'b1) begin n_err++; $display("FAIL dir%0d_in_ready: got %b want 1", i, in_ready); end
            @(negedge clk);
            in_valid = 1'b0;
            n = 1;
            while (out_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
            n_vec++;
            if (n != SA_W) begin n_err++; $display("FAIL dir%0d_latency: got %0d want %0d", i, n, SA_W); end
            n_vec++;
            if (obs !== tr[i]) begin n_err++; $display("FAIL dir%0d_result: got %h want %h", i, obs, tr[i]); end
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [RW-1:0] q [$];
        logic [RW-1:0] held;
        logic          stalled, exp_ir;
        int            occ;
        q = {}; occ = 0; stalled = 1'b0; held = '0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (stalled) begin
                n_vec++;
                if (out_valid !== 1'b1 || obs !== held) begin
                    n_err++; $display("FAIL rnd_hold c%0d: got %b/%h want 1/%h", c, out_valid, obs, held);
                end
            end
            in_valid  = (c < 360) ? 1'($urandom_range(0, 3) != 0) : 1'b0;
            in_mant   = WIDTH'($urandom) >> $urandom_range(0, WIDTH);
            in_exp    = ($urandom_range(0, 2) == 0) ? EXP_W'($urandom_range(0, 30)) : EXP_W'($urandom);
            in_lim    = 1'($urandom_range(0, 1));
            out_ready = (c < 360) ? 1'($urandom_range(0, 2) != 0) : 1'b1;
            #1;
            exp_ir = !(occ == SA_W && !out_ready);
            n_vec++;
            if (in_ready !== exp_ir) begin n_err++; $display("FAIL rnd_in_ready c%0d: got %b want %b", c, in_ready, exp_ir); end
            if (out_valid === 1'b1 && out_ready) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_err++; $display("FAIL rnd_extra c%0d: got %h want none", c, obs);
                end else begin
                    if (obs !== q[0]) begin n_err++; $display("FAIL rnd_result c%0d: got %h want %h", c, obs, q[0]); end
                    void'(q.pop_front());
                    occ--;
                end
            end
            if (in_valid && in_ready === 1'b1) begin
                q.push_back(ref_beat(in_mant, in_exp, in_lim));
                occ++;
            end
            stalled = (out_valid === 1'b1) && !out_ready;
            held    = obs;
        end
        n_vec++;
        if (q.size() != 0) begin n_err++; $display("FAIL rnd_drain: got %0d left want 0", q.size()); end
        in_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] bm [8];
        logic [EXP_W-1:0] be [8];
        logic             bl [8];
        logic [RW-1:0]    q [$];
        logic [RW-1:0]    held;
        logic             stalled, exp_ir;
        int               occ, sent, got, c;
        for (int i = 0; i < 8; i++) begin
            bm[i] = WIDTH'($urandom) >> $urandom_range(0, WIDTH-1);
            be[i] = EXP_W'($urandom);
            bl[i] = 1'($urandom_range(0, 1));
        end
        q = {}; occ = 0; sent = 0; got = 0; c = 0; stalled = 1'b0; held = '0;
        while (got < 8 && c < 60) begin
            @(negedge clk);
            if (stalled) begin
                n_vec++;
                if (out_valid !== 1'b1 || obs !== held) begin
                    n_err++; $display("FAIL b2b_hold c%0d: got %b/%h want 1/%h", c, out_valid, obs, held);
                end
            end
            in_valid  = (sent < 8);
            in_mant   = bm[sent % 8]; in_exp = be[sent % 8]; in_lim = bl[sent % 8];
            out_ready = !(c >= 6 && c <= 9);
            #1;
            exp_ir = !(occ == SA_W && !out_ready);
            n_vec++;
            if (in_ready !== exp_ir) begin n_err++; $display("FAIL b2b_in_ready c%0d: got %b want %b", c, in_ready, exp_ir); end
            if (c == 6) begin
                n_vec++;
                if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_full c6: got %b want 0", in_ready); end
            end
            if (out_valid === 1'b1 && out_ready) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_err++; $display("FAIL b2b_extra c%0d: got %h want none", c, obs);
                end else begin
                    if (obs !== q[0]) begin n_err++; $display("FAIL b2b_result c%0d: got %h want %h", c, obs, q[0]); end
                    void'(q.pop_front());
                    occ--; got++;
                end
            end
            if (in_valid && in_ready === 1'b1) begin
                q.push_back(ref_beat(in_mant, in_exp, in_lim));
                occ++; sent++;
            end
            stalled = (out_valid === 1'b1) && !out_ready;
            held    = obs;
            c++;
        end
        n_vec++;
        if (got != 8) begin n_err++; $display("FAIL b2b_count: got %0d want 8", got); end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_midstream();
        int          n, seen;
        logic [RW-1:0] want;
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_mant = 24'h000010 << i; in_exp = 8'd40; in_lim = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL rstm_pre_valid: got %b want 1", out_valid); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstm_async_valid: got %b want 0", out_valid); end
        n_vec++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL rstm_async_ready: got %b want 1", in_ready); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen++;
        end
        n_vec++;
        if (seen != 0) begin n_err++; $display("FAIL rstm_ghost: got %0d beats want 0", seen); end
        in_valid = 1'b1; in_mant = 24'h0003A0; in_exp = 8'd9; in_lim = 1'b1;
        want = ref_beat(in_mant, in_exp, in_lim);
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (out_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        n_vec++;
        if (n != SA_W) begin n_err++; $display("FAIL rstm_latency: got %0d want %0d", n, SA_W); end
        n_vec++;
        if (obs !== want) begin n_err++; $display("FAIL rstm_result: got %h want %h", obs, want); end
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
